// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one fixed-latency 64-bit memory bus.
// One transaction in flight; every output is a registered copy of the FSM state.
module mem_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 64,
  parameter int DW  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [3:0]    p0_size,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [3:0]    p1_size,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          m_valid,
  output logic          m_rw,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_size,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          win1;

  logic          valid_d, rw_d, busy_d;
  logic          gnt0_d, gnt1_d;
  logic          done0_d, done1_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [3:0]    size_d;
  logic [DW-1:0] rdata0_d, rdata1_d;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    valid_d  = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rw_d     = m_rw;
    addr_d   = m_addr;
    wdata_d  = m_wdata;
    size_d   = m_size;
    rdata0_d = p0_rdata;
    rdata1_d = p1_rdata;
    busy_d   = busy;
    // On contention the port that did not win last time goes first
    win1     = p1_req & (~p0_req | ~last_q);

    unique case (state_q)
      IDLE: begin
        if (p0_req | p1_req) begin
          valid_d = 1'b1;
          rw_d    = win1 ? p1_rw    : p0_rw;
          addr_d  = win1 ? p1_addr  : p0_addr;
          wdata_d = win1 ? p1_wdata : p0_wdata;
          size_d  = win1 ? p1_size  : p0_size;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          owner_d = win1;
          last_d  = win1;
          cnt_d   = LAT_C;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!m_rw) begin
            if (owner_q) rdata1_d = m_rdata;
            else         rdata0_d = m_rdata;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      m_valid  <= 1'b0;
      m_rw     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_size   <= 4'd0;
      p0_gnt   <= 1'b0;
      p1_gnt   <= 1'b0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      m_valid  <= valid_d;
      m_rw     <= rw_d;
      m_addr   <= addr_d;
      m_wdata  <= wdata_d;
      m_size   <= size_d;
      p0_gnt   <= gnt0_d;
      p1_gnt   <= gnt1_d;
      p0_done  <= done0_d;
      p1_done  <= done1_d;
      p0_rdata <= rdata0_d;
      p1_rdata <= rdata1_d;
      busy     <= busy_d;
    end
  end

endmodule
